alu_issue: RTL
==============

# alu_issue

Pipelined initiator for the combinational ALU in the execute stage. Accepts a decoded MIPS instruction and its register operands over a valid/ready handshake, then selects aluop and portA/portB, including immediate extension and shift amounts. It registers the ALU response with signed-overflow trap and illegal-op flags and hands the result downstream over a second valid/ready handshake. It is a two-register pipeline that sustains one instruction per cycle.

## Interface
- No parameters; word width is fixed at 32 and aluop_t comes from cpu_types_pkg.
- CLK  in  1  rising-edge clock
- RST  in  1  asynchronous, active-high reset
- flush  in  1  synchronous squash of all in-flight instructions
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid && in_ready at an edge
- opcode  in  6  instruction [31:26]
- funct  in  6  instruction [5:0]
- shamt  in  5  instruction [10:6]
- imm16  in  16  instruction [15:0]
- rdat1  in  32  rs value
- rdat2  in  32  rt value
- aluop  out  aluop_t  to ALU
- portA, portB  out  32  to ALU
- alu_out  in  32  ALU output_port
- alu_zero, alu_ovf  in  1  ALU zero and overflow
- res_valid  out  1  result valid
- res_ready  in  1  downstream accepts when res_valid && res_ready
- res_data  out  32  result word
- res_zero  out  1  result == 0
- res_trap  out  1  signed overflow on ADD/ADDI/SUB
- res_illegal  out  1  unsupported encoding

## Operation
- S1 (issue register) holds the decoded aluop, portA, portB, is_trapping and illegal; aluop/portA/portB are driven directly from S1.
- S2 (result register) captures alu_out, alu_zero, (alu_ovf && is_trapping) and illegal from S1.
- R-type (opcode 0):
  - SLL 0x00 / SRL 0x02: portA=rdat2, portB={27'b0,shamt}.
  - ADD 0x20 and ADDU 0x21 map to ALU_ADD; SUB 0x22 and SUBU 0x23 map to ALU_SUB. Only 0x20 and 0x22 are trapping.
  - AND 0x24, OR 0x25, XOR 0x26, NOR 0x27, SLT 0x2A, SLTU 0x2B map to the matching op.
  - All R-type ops other than the shifts use portA=rdat1, portB=rdat2.
- I-type: portA=rdat1.
  - portB=sign-extended imm16 for ADDI 0x08 (trapping), ADDIU 0x09, SLTI 0x0A, SLTIU 0x0B. SLTIU compares unsigned against the sign-extended value.
  - portB=zero-extended imm16 for ANDI 0x0C, ORI 0x0D, XORI 0x0E.
  - LUI 0x0F: ALU_SLL, portA={16'b0,imm16}, portB=16.
  - BEQ 0x04 / BNE 0x05: ALU_SUB on rdat1/rdat2, non-trapping; the branch decision uses res_zero.
- Any other opcode/funct sets illegal=1, aluop=ALU_ADD, portA=portB=0. Such an instruction still flows through, giving res_data=0 and res_illegal=1.
- A trap does not suppress the result: res_data still holds the wrapped sum or difference.

## Timing
- Reset (async, RST=1): S1 and S2 valid bits, aluop, portA, portB, res_data and all res flags go to 0; in_ready=1 once RST deasserts.
- Latency is 2 edges: accept at edge N, S1 is valid after N, and res_valid is high after edge N+1 when S2 is free.
- S2 is free when !res_valid || res_ready. S1 advances into S2 when S1 is valid and S2 is free.
- in_ready = !flush && (!S1_valid || S2_free).
- Throughput is 1 per cycle with res_ready held high. Back-to-back accepts keep res_valid continuously high.
- Stall behaviour with res_ready=0 and res_valid=1:
  - S2 holds its contents and outputs stable.
  - S1 holds, so aluop/portA/portB stay stable.
  - in_ready=0 if S1 is valid.
- Simultaneous res_ready and a new accept: S2 is reloaded from S1 and S1 is reloaded from the input on the same edge, with no bubble.
- flush=1 at an edge clears both valid bits. The payload is don't-care and no request is accepted that cycle. flush overrides res_ready and in_valid.
- RST asserted mid-operation drops all in-flight work immediately, with no partial result.

## Test plan
- ADD rdat1=0x7FFFFFFF, rdat2=1, funct 0x20: after 2 edges res_data=0x80000000, res_trap=1. The same operands with ADDU 0x21 give res_trap=0.
- ADDIU rdat1=5, imm16=0xFFFF: res_data=4. ANDI rdat1=0xFFFFFFFF, imm16=0xFFFF: res_data=0x0000FFFF. LUI imm16=0x1234: res_data=0x12340000.
- SLL rdat2=1, shamt=31: portA=1, portB=31, res_data=0x80000000. BEQ rdat1=rdat2=0xA5: res_zero=1.
- Streaming 8 ADDUs with res_ready=1: one result per cycle in order, first res_valid 2 edges after the first accept.
- Stall then flush:
  - Hold res_ready=0 for 3 cycles with 3 requests offered: in_ready drops after the second accept, and res_data is stable across the stall.
  - Releasing res_ready drains the results in order.
  - flush mid-stall: res_valid=0 next cycle.
- opcode 0x3F: res_illegal=1, res_data=0. Asserting RST asynchronously while res_valid=1: res_valid=0 with no clock edge.

Source files
------------

// File: rtl/alu_issue.sv
// Execute-stage ALU initiator: decodes a MIPS instruction into aluop/portA/portB (S1),
// then registers the ALU response with trap/illegal flags (S2) behind valid/ready handshakes.
package cpu_types_pkg;
    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_ADD  = 4'd2,
        ALU_SUB  = 4'd3,
        ALU_AND  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_XOR  = 4'd6,
        ALU_NOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;
endpackage

module alu_issue
    import cpu_types_pkg::*;
(
    input  logic        CLK,
    input  logic        RST,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm16,
    input  logic [31:0] rdat1,
    input  logic [31:0] rdat2,
    output aluop_t      aluop,
    output logic [31:0] portA,
    output logic [31:0] portB,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    input  logic        alu_ovf,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_zero,
    output logic        res_trap,
    output logic        res_illegal
);

    logic        s1_valid_q, s1_valid_d;
    aluop_t      s1_aluop_q, s1_aluop_d;
    logic [31:0] s1_porta_q, s1_porta_d;
    logic [31:0] s1_portb_q, s1_portb_d;
    logic        s1_trap_q, s1_trap_d;
    logic        s1_ill_q, s1_ill_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_data_q, s2_data_d;
    logic        s2_zero_q, s2_zero_d;
    logic        s2_trap_q, s2_trap_d;
    logic        s2_ill_q, s2_ill_d;

    aluop_t      dec_aluop;
    logic [31:0] dec_porta, dec_portb;
    logic        dec_trap, dec_ill;
    logic [31:0] imm_sext, imm_zext;
    logic        s2_free, advance, accept;

    assign imm_sext = {{16{imm16[15]}}, imm16};
    assign imm_zext = {16'b0, imm16};

    // Unsupported encodings fall through as ADD 0+0 so they still produce a (zero) result.
    always_comb begin
        dec_aluop = ALU_ADD;
        dec_porta = 32'b0;
        dec_portb = 32'b0;
        dec_trap  = 1'b0;
        dec_ill   = 1'b0;
        case (opcode)
            6'h00: begin
                dec_porta = rdat1;
                dec_portb = rdat2;
                case (funct)
                    6'h00: begin dec_aluop = ALU_SLL; dec_porta = rdat2; dec_portb = {27'b0, shamt}; end
                    6'h02: begin dec_aluop = ALU_SRL; dec_porta = rdat2; dec_portb = {27'b0, shamt}; end
                    6'h20: begin dec_aluop = ALU_ADD; dec_trap = 1'b1; end
                    6'h21: dec_aluop = ALU_ADD;
                    6'h22: begin dec_aluop = ALU_SUB; dec_trap = 1'b1; end
                    6'h23: dec_aluop = ALU_SUB;
                    6'h24: dec_aluop = ALU_AND;
                    6'h25: dec_aluop = ALU_OR;
                    6'h26: dec_aluop = ALU_XOR;
                    6'h27: dec_aluop = ALU_NOR;
                    6'h2A: dec_aluop = ALU_SLT;
                    6'h2B: dec_aluop = ALU_SLTU;
                    default: begin
                        dec_ill   = 1'b1;
                        dec_porta = 32'b0;
                        dec_portb = 32'b0;
                    end
                endcase
            end
            6'h04, 6'h05: begin dec_aluop = ALU_SUB; dec_porta = rdat1; dec_portb = rdat2; end
            6'h08: begin dec_aluop = ALU_ADD;  dec_porta = rdat1; dec_portb = imm_sext; dec_trap = 1'b1; end
            6'h09: begin dec_aluop = ALU_ADD;  dec_porta = rdat1; dec_portb = imm_sext; end
            6'h0A: begin dec_aluop = ALU_SLT;  dec_porta = rdat1; dec_portb = imm_sext; end
            6'h0B: begin dec_aluop = ALU_SLTU; dec_porta = rdat1; dec_portb = imm_sext; end
            6'h0C: begin dec_aluop = ALU_AND;  dec_porta = rdat1; dec_portb = imm_zext; end
            6'h0D: begin dec_aluop = ALU_OR;   dec_porta = rdat1; dec_portb = imm_zext; end
            6'h0E: begin dec_aluop = ALU_XOR;  dec_porta = rdat1; dec_portb = imm_zext; end
            6'h0F: begin dec_aluop = ALU_SLL;  dec_porta = imm_zext; dec_portb = 32'd16; end
            default: dec_ill = 1'b1;
        endcase
    end

    assign s2_free  = !s2_valid_q || res_ready;
    assign advance  = s1_valid_q && s2_free;
    assign in_ready = !flush && (!s1_valid_q || s2_free);
    assign accept   = in_valid && in_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_aluop_d = s1_aluop_q;
        s1_porta_d = s1_porta_q;
        s1_portb_d = s1_portb_q;
        s1_trap_d  = s1_trap_q;
        s1_ill_d   = s1_ill_q;
        if (flush) begin
            s1_valid_d = 1'b0;
        end else if (accept) begin
            s1_valid_d = 1'b1;
            s1_aluop_d = dec_aluop;
            s1_porta_d = dec_porta;
            s1_portb_d = dec_portb;
            s1_trap_d  = dec_trap;
            s1_ill_d   = dec_ill;
        end else if (advance) begin
            s1_valid_d = 1'b0;
        end
    end

    // S2 captures the ALU response to whatever S1 is presenting this cycle.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_data_d  = s2_data_q;
        s2_zero_d  = s2_zero_q;
        s2_trap_d  = s2_trap_q;
        s2_ill_d   = s2_ill_q;
        if (flush) begin
            s2_valid_d = 1'b0;
        end else if (advance) begin
            s2_valid_d = 1'b1;
            s2_data_d  = alu_out;
            s2_zero_d  = alu_zero;
            s2_trap_d  = alu_ovf && s1_trap_q;
            s2_ill_d   = s1_ill_q;
        end else if (res_ready) begin
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_valid_q <= 1'b0;
            s1_aluop_q <= ALU_SLL;
            s1_porta_q <= 32'b0;
            s1_portb_q <= 32'b0;
            s1_trap_q  <= 1'b0;
            s1_ill_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_data_q  <= 32'b0;
            s2_zero_q  <= 1'b0;
            s2_trap_q  <= 1'b0;
            s2_ill_q   <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_aluop_q <= s1_aluop_d;
            s1_porta_q <= s1_porta_d;
            s1_portb_q <= s1_portb_d;
            s1_trap_q  <= s1_trap_d;
            s1_ill_q   <= s1_ill_d;
            s2_valid_q <= s2_valid_d;
            s2_data_q  <= s2_data_d;
            s2_zero_q  <= s2_zero_d;
            s2_trap_q  <= s2_trap_d;
            s2_ill_q   <= s2_ill_d;
        end
    end

    assign aluop       = s1_aluop_q;
    assign portA       = s1_porta_q;
    assign portB       = s1_portb_q;
    assign res_valid   = s2_valid_q;
    assign res_data    = s2_data_q;
    assign res_zero    = s2_zero_q;
    assign res_trap    = s2_trap_q;
    assign res_illegal = s2_ill_q;

endmodule
